vga_coord_gen: RTL

- Upstream timing stage for the sphere renderer and other 80x60 effect renderers.
- Generates 640x480@60 VGA timing from a 25 MHz pixel rate and drives the compressed 7-bit pixel coordinates (compr_hrw, compr_vrw) those renderers consume.
- Delays sync and active-video strobes so they line up with a renderer's registered colour output.
- Emits a once-per-frame tick for effect animation.

---
 rtl/vga_coord_gen.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vga_coord_gen.sv
// 640x480@60 VGA timing with compressed 80x60 renderer coordinates and a frame tick.
// Optional macro VGA_COORD_PIXDIV2_EN: derive pix_en from a clk/2 toggle for a 50 MHz board clock.
module vga_coord_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SHIFT      = 3,
  parameter int PIPE_DELAY = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [6:0] compr_hrw,
  output logic [6:0] compr_vrw,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       frame_tick
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam int DL_N = (PIPE_DELAY > 0) ? PIPE_DELAY : 1;
  localparam logic [2:0] ST_IDLE = 3'b110; // {hsync, vsync, active} inactive levels

  logic pix_en;
`ifdef VGA_COORD_PIXDIV2_EN
  logic pix_q;
  always_ff @(posedge clk) begin
    if (reset) pix_q <= 1'b0;
    else       pix_q <= ~pix_q;
  end
  assign pix_en = pix_q;
`else
  assign pix_en = 1'b1;
`endif

  logic [9:0] h_q, h_d, v_q, v_d;
  logic [6:0] ch_q, ch_d, cv_q, cv_d;
  logic       ft_q, ft_d;
  logic [2:0] st_q, st_d;
  logic       vis, hs_n, vs_n;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  assign vis  = (h_q < H_VIS) && (v_q < V_VIS);
  assign hs_n = !((h_q >= HS_START) && (h_q < HS_END));
  assign vs_n = !((v_q >= VS_START) && (v_q < VS_END));

  always_comb begin
    ch_d = ch_q;
    cv_d = cv_q;
    st_d = st_q;
    // Tick is qualified by pix_en but not held, so it stays one clk wide.
    ft_d = pix_en && (h_q == '0) && (v_q == '0);
    if (pix_en) begin
      ch_d = vis ? 7'(h_q >> SHIFT) : 7'd0;
      cv_d = vis ? 7'(v_q >> SHIFT) : 7'd0;
      st_d = {hs_n, vs_n, vis};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q  <= '0;
      v_q  <= '0;
      ch_q <= '0;
      cv_q <= '0;
      ft_q <= 1'b0;
      st_q <= ST_IDLE;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      ch_q <= ch_d;
      cv_q <= cv_d;
      ft_q <= ft_d;
      st_q <= st_d;
    end
  end

  logic [2:0] st_out;
  generate
    if (PIPE_DELAY == 0) begin : g_nodl
      assign st_out = st_q;
    end else begin : g_dl
      logic [DL_N-1:0][2:0] dl_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          dl_q <= {DL_N{ST_IDLE}};
        end else if (pix_en) begin
          dl_q[0] <= st_q;
          for (int i = 1; i < DL_N; i++) dl_q[i] <= dl_q[i-1];
        end
      end
      assign st_out = dl_q[DL_N-1];
    end
  endgenerate

  assign hcount     = h_q;
  assign vcount     = v_q;
  assign compr_hrw  = ch_q;
  assign compr_vrw  = cv_q;
  assign frame_tick = ft_q;
  assign hsync      = st_out[2];
  assign vsync      = st_out[1];
  assign active     = st_out[0];
endmodule
